// File: rtl/sram_req_master_pkg.sv
// Shared encodings for the sram_ctl request master: FSM states, the rw
// polarity used on the controller interface, and watchdog sizing.
package sram_req_master_pkg;

  typedef enum logic [1:0] {
    SRM_IDLE  = 2'd0,
    SRM_ISSUE = 2'd1,
    SRM_WAIT  = 2'd2,
    SRM_RESP  = 2'd3
  } srm_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int BE_W = 4;

  // One spare bit above the limit so the counter can saturate past it.
  function automatic int wdog_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

  // sram_ctl takes byte enables active-low.
  function automatic logic [BE_W-1:0] be_to_mem(input logic [BE_W-1:0] be);
    return ~be;
  endfunction

endpackage

// File: rtl/sram_req_master_watchdog.sv
// Access watchdog: clear/enable saturating counter that flags expiry once it
// has counted LIMIT-1 enabled cycles since the last clear.
module access_watchdog
  import sram_req_master_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wdog_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_AT  = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count >= EXP_AT);

endmodule

// File: rtl/sram_req_master.sv
// Request-side master for sram_ctl: takes one CPU load/store at a time,
// drives the controller's start/rw/addr/data handshake and returns a response.
module sram_req_master
  import sram_req_master_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_start_o,
  output logic              mem_rw_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [BE_W-1:0]   mem_be_no,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_r_ready_i,
  input  logic              mem_w_finish_i,
  input  logic              mem_busy_i
);

  srm_state_e state;

  logic wdog_clr, wdog_en, wdog_expired;
  logic rd_done, wr_done;

  // The counter restarts on the same edge that launches the start pulse,
  // so expiry is measured from the moment sram_ctl sees the access.
  assign wdog_clr = (state == SRM_ISSUE) && !mem_busy_i;
  assign wdog_en  = (state == SRM_WAIT);

  access_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  // Only the strobe matching the latched direction counts as completion.
  assign rd_done = (mem_rw_o == RW_READ)  && mem_r_ready_i;
  assign wr_done = (mem_rw_o == RW_WRITE) && mem_w_finish_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= SRM_IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      mem_start_o <= 1'b0;
      mem_rw_o    <= RW_READ;
      mem_data_o  <= '0;
      mem_be_no   <= '1;
      mem_addr_o  <= '0;
    end else begin
      mem_start_o <= 1'b0;
      unique case (state)
        SRM_IDLE: begin
          if (req_valid_i) begin
            mem_rw_o    <= req_we_i ? RW_WRITE : RW_READ;
            mem_addr_o  <= req_addr_i;
            mem_data_o  <= req_wdata_i;
            mem_be_no   <= be_to_mem(req_be_i);
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b0;
            // A store with no enabled bytes has nothing to do in memory.
            if (req_we_i && (req_be_i == '0)) begin
              rsp_valid_o <= 1'b1;
              state       <= SRM_RESP;
            end else begin
              state <= SRM_ISSUE;
            end
          end
        end

        SRM_ISSUE: begin
          if (!mem_busy_i) begin
            mem_start_o <= 1'b1;
            state       <= SRM_WAIT;
          end
        end

        SRM_WAIT: begin
          if (rd_done) begin
            rsp_rdata_o <= mem_data_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end else if (wr_done) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end else if (wdog_expired) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= SRM_RESP;
          end
        end

        SRM_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= SRM_IDLE;
          end
        end

        default: state <= SRM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_req_master.md
Name: sram_req_master

Overview:
- Request-side master for `sram_ctl`.
- Accepts one CPU load/store at a time on a valid/ready request channel and converts it into the controller's start/rw/addr/data handshake.
- Waits for read-ready or write-finish, then returns the result on a valid/ready response channel.
- Sits between the CPU memory stage and `sram_ctl`, and adds busy-gating, an access watchdog and an error response.

Parameters:
- `ADDR_W`, 24, word address width; matches `sram_ctl` `addr_i`.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 64, maximum cycles in WAIT before the access is aborted with an error.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  CPU request valid.
- `req_ready_o`  out  1  master can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  ADDR_W  word address.
- `req_wdata_i`  in  DATA_W  store data.
- `req_be_i`  in  4  byte enables, active-high.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  CPU accepts the response.
- `rsp_rdata_o`  out  DATA_W  load data; 0 for stores and errors.
- `rsp_err_o`  out  1  watchdog timeout occurred.
- `mem_start_o`  out  1  to `sram_ctl` `start_i`; single-cycle pulse.
- `mem_rw_o`  out  1  to `rw_i`; 1 = read, 0 = write.
- `mem_data_o`  out  DATA_W  to `data_i`.
- `mem_be_no`  out  4  to `data_be_i`; active-low, equal to ~be.
- `mem_addr_o`  out  ADDR_W  to `addr_i`.
- `mem_data_i`  in  DATA_W  from `data_o`.
- `mem_r_ready_i`  in  1  from `r_ready_o`.
- `mem_w_finish_i`  in  1  from `w_finish_o`.
- `mem_busy_i`  in  1  from `busy_o`.

Behaviour:
- **Reset values:** state IDLE. `req_ready_o`=1, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_rdata_o`=0, `mem_start_o`=0, `mem_rw_o`=1, `mem_data_o`=0, `mem_be_no`=4'hF, `mem_addr_o`=0, watchdog=0.
- **Reset mid-operation:** immediately returns to the reset values and drops any pending response. `sram_ctl` is reset by the same net.
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready_o`=1.
  - On `req_valid_i`: register we/addr/wdata/be into the `mem_*` outputs; `mem_rw_o`=~we.
  - If `req_we_i`=1 and `be`=0: go straight to RESP with no memory access (null store).
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `req_ready_o`=0.
  - If `mem_busy_i`=0: assert `mem_start_o` for exactly this cycle, clear the watchdog, go to WAIT.
  - If `mem_busy_i`=1: hold in ISSUE with `mem_start_o`=0.
- **WAIT:**
  - Watchdog increments each cycle.
  - Read completes on `mem_r_ready_i`=1: latch `mem_data_i` into `rsp_rdata_o` on that edge.
  - Write completes on `mem_w_finish_i`=1: `rsp_rdata_o`=0.
  - Either completion goes to RESP with `rsp_err_o`=0.
  - Completion strobes of the wrong type (e.g. `w_finish` during a read) are ignored.
  - If the watchdog reaches TIMEOUT-1 with no completion: go to RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0.
  - A completion in the same cycle as the timeout wins: `rsp_err_o`=0.
- **RESP:**
  - `rsp_valid_o`=1; `rsp_rdata_o` and `rsp_err_o` stable until `rsp_ready_i`=1.
  - On the handshake go to IDLE and deassert `rsp_valid_o`.
  - `req_ready_o` stays 0 in RESP, so there is no request/response overlap.
- **Latency:**
  - Request acceptance to start pulse: 1 cycle minimum.
  - `r_ready`/`w_finish` to `rsp_valid_o`: 1 cycle.
  - Null store: `rsp_valid_o` 1 cycle after acceptance.
- **Output stability:** `mem_addr_o`, `mem_data_o`, `mem_be_no` and `mem_rw_o` stay stable from acceptance until return to IDLE.
- **Completion strobes outside WAIT** are ignored.
- **Watchdog width:** `$clog2(TIMEOUT)+1` bits; saturates and never wraps.

Decomposition:
- **Shared package constants:**
  - State encoding `SRM_IDLE`=2'd0, `SRM_ISSUE`=2'd1, `SRM_WAIT`=2'd2, `SRM_RESP`=2'd3.
  - `RW_READ`=1'b1, `RW_WRITE`=1'b0.
  - These go in `common.vh`, shared with `sram_ctl`.
- **Sub-module:** one, `access_watchdog`, a clear/enable saturating counter with an expire flag.

Test Plan:
- **Basic read:** preload word 0x000010 = 0xDEADBEEF; issue a load with be=4'hF → exactly one `mem_start_o` pulse with `mem_rw_o`=1 and `mem_addr_o`=0x000010; `rsp_valid_o` with `rsp_rdata_o`=0xDEADBEEF and `rsp_err_o`=0.
- **Byte write then read:** store 0x11223344 with be=4'b0011 to 0x000020 over an old value of 0xAABBCCDD → `mem_be_no`=4'b1100; the following load returns 0xAABB3344.
- **Busy gating:** hold `mem_busy_i`=1 for 5 cycles after acceptance → `mem_start_o` stays 0; it pulses on the first cycle busy=0, and `req_ready_o` is 0 throughout.
- **Timeout:** TIMEOUT=8 with a stub that never completes → `rsp_valid_o` 8 cycles after start with `rsp_err_o`=1 and `rsp_rdata_o`=0; the next request proceeds normally.
- **Back-pressure and null store:** hold `rsp_ready_i`=0 for 4 cycles → response fields hold stable and `req_ready_o`=0. A store with be=0 produces no `mem_start_o` and `rsp_valid_o` on the next cycle.
- **Async reset mid-WAIT:** drive `rst_i` low during WAIT, asynchronously to the clock → all outputs reach their reset values before the next edge; after release, a fresh read succeeds.
